// File: rtl/line_fetcher.sv
// Scanline fetcher: reads WORDS_PER_LINE 16-bit words per line over Wishbone into ping-pong line buffers.
// Optional Wishbone ERR termination (err_i / sticky err_o) is enabled by defining LINE_FETCHER_ERR_EN.
module line_fetcher #(
    parameter int ADR_W          = 23,
    parameter int WORDS_PER_LINE = 40,
    parameter int BUF_AW         = 6
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              hsync_i,
    input  logic              vsync_i,
    input  logic              den_i,
    input  logic [ADR_W-1:0]  fb_adr_i,
    input  logic [ADR_W-1:0]  modulo_i,
    output logic              cyc_o,
    output logic              stb_o,
    output logic [ADR_W-1:0]  adr_o,
    input  logic [15:0]       dat_i,
    input  logic              ack_i,
    output logic              lb_we_o,
    output logic              lb_sel_o,
    output logic [BUF_AW-1:0] lb_adr_o,
    output logic [15:0]       lb_dat_o,
    output logic              busy_o,
    output logic              overrun_o
`ifdef LINE_FETCHER_ERR_EN
   ,input  logic              err_i
   ,output logic              err_o
`endif
);

    typedef enum logic {
        IDLE,
        FETCH
    } state_t;

    localparam logic [ADR_W-1:0]  LINE_LEN = ADR_W'(WORDS_PER_LINE);
    localparam logic [BUF_AW-1:0] LAST_IDX = BUF_AW'(WORDS_PER_LINE - 1);

    state_t             state_q, state_d;
    logic [ADR_W-1:0]   line_ptr_q, line_ptr_d;
    logic [ADR_W-1:0]   adr_q, adr_d;
    logic [BUF_AW-1:0]  word_cnt_q, word_cnt_d;
    logic [BUF_AW-1:0]  lb_adr_q, lb_adr_d;
    logic [15:0]        lb_dat_q, lb_dat_d;
    logic               cyc_q, cyc_d;
    logic               lb_we_q, lb_we_d;
    logic               lb_sel_q, lb_sel_d;
    logic               busy_q, busy_d;
    logic               overrun_q, overrun_d;
    logic               trig_q;
    logic               err_q, err_d;

    logic               trig;
    logic               start;
    logic               beat_err;
    logic               line_end;
    logic [ADR_W-1:0]   next_line_ptr;

    assign trig          = hsync_i & den_i;
    assign start         = trig & ~trig_q;
    assign next_line_ptr = line_ptr_q + LINE_LEN + modulo_i;

`ifdef LINE_FETCHER_ERR_EN
    assign beat_err = err_i;
    assign err_o    = err_q;
`else
    assign beat_err = 1'b0;
`endif

    // An ERR beat closes the line exactly like the final ACK, minus the buffer write.
    assign line_end = beat_err | (ack_i & (word_cnt_q == LAST_IDX));

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
        state_d    = state_q;
        line_ptr_d = line_ptr_q;
        adr_d      = adr_q;
        word_cnt_d = word_cnt_q;
        lb_adr_d   = lb_adr_q;
        lb_dat_d   = lb_dat_q;
        cyc_d      = cyc_q;
        lb_we_d    = 1'b0;
        lb_sel_d   = lb_sel_q;
        busy_d     = busy_q;
        overrun_d  = 1'b0;
        err_d      = err_q;

        if (vsync_i) begin
            state_d    = IDLE;
            line_ptr_d = fb_adr_i;
            adr_d      = fb_adr_i;
            lb_sel_d   = 1'b0;
            cyc_d      = 1'b0;
            busy_d     = 1'b0;
            err_d      = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    adr_d = line_ptr_q;
                    if (start) begin
                        state_d    = FETCH;
                        cyc_d      = 1'b1;
                        busy_d     = 1'b1;
                        word_cnt_d = '0;
                    end
                end
                FETCH: begin
                    if (start) begin
                        overrun_d = 1'b1;
                    end
                    if (ack_i && !beat_err) begin
                        lb_we_d  = 1'b1;
                        lb_adr_d = word_cnt_q;
                        lb_dat_d = dat_i;
                    end
                    if (beat_err) begin
                        err_d = 1'b1;
                    end
                    if (line_end) begin
                        state_d    = IDLE;
                        cyc_d      = 1'b0;
                        busy_d     = 1'b0;
                        lb_sel_d   = ~lb_sel_q;
                        line_ptr_d = next_line_ptr;
                        adr_d      = next_line_ptr;
                    end else if (ack_i) begin
                        adr_d      = adr_q + ADR_W'(1);
                        word_cnt_d = word_cnt_q + BUF_AW'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= IDLE;
            line_ptr_q <= '0;
            adr_q      <= '0;
            word_cnt_q <= '0;
            lb_adr_q   <= '0;
            lb_dat_q   <= '0;
            cyc_q      <= 1'b0;
            lb_we_q    <= 1'b0;
            lb_sel_q   <= 1'b0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
            trig_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            state_q    <= state_d;
            line_ptr_q <= line_ptr_d;
            adr_q      <= adr_d;
            word_cnt_q <= word_cnt_d;
            lb_adr_q   <= lb_adr_d;
            lb_dat_q   <= lb_dat_d;
            cyc_q      <= cyc_d;
            lb_we_q    <= lb_we_d;
            lb_sel_q   <= lb_sel_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
            trig_q     <= trig;
            err_q      <= err_d;
        end
    end

    assign cyc_o     = cyc_q;
    assign stb_o     = cyc_q;
    assign adr_o     = adr_q;
    assign lb_we_o   = lb_we_q;
    assign lb_sel_o  = lb_sel_q;
    assign lb_adr_o  = lb_adr_q;
    assign lb_dat_o  = lb_dat_q;
    assign busy_o    = busy_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_line_fetcher.sv
// Directed bench for line_fetcher with WORDS_PER_LINE=4: stimulus table plus hand-written corner sequences.
// Define LINE_FETCHER_ERR_EN to also exercise the ERR termination path.
module tb_line_fetcher;

    localparam int ADR_W = 23;
    localparam int WPL   = 4;
    localparam int BAW   = 6;

    logic             clk_i = 1'b0;
    logic             reset_ni;
    logic             hsync_i, vsync_i, den_i;
    logic [ADR_W-1:0] fb_adr_i, modulo_i;
    logic             cyc_o, stb_o;
    logic [ADR_W-1:0] adr_o;
    logic [15:0]      dat_i;
    logic             ack_i;
    logic             lb_we_o, lb_sel_o;
    logic [BAW-1:0]   lb_adr_o;
    logic [15:0]      lb_dat_o;
    logic             busy_o, overrun_o;
`ifdef LINE_FETCHER_ERR_EN
    logic             err_i;
    logic             err_o;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    line_fetcher #(.ADR_W(ADR_W), .WORDS_PER_LINE(WPL), .BUF_AW(BAW)) dut (
        .clk_i     (clk_i),
        .reset_ni  (reset_ni),
        .hsync_i   (hsync_i),
        .vsync_i   (vsync_i),
        .den_i     (den_i),
        .fb_adr_i  (fb_adr_i),
        .modulo_i  (modulo_i),
        .cyc_o     (cyc_o),
        .stb_o     (stb_o),
        .adr_o     (adr_o),
        .dat_i     (dat_i),
        .ack_i     (ack_i),
        .lb_we_o   (lb_we_o),
        .lb_sel_o  (lb_sel_o),
        .lb_adr_o  (lb_adr_o),
        .lb_dat_o  (lb_dat_o),
        .busy_o    (busy_o),
        .overrun_o (overrun_o)
`ifdef LINE_FETCHER_ERR_EN
       ,.err_i     (err_i)
       ,.err_o     (err_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        hs, den, vs, ack;
        logic [15:0] dat;
        logic        cyc;
        logic [22:0] adr;
        logic        we;
        logic [5:0]  lidx;
        logic [15:0] ldat;
        logic        sel, busy, ovr;
    } vec_t;

    vec_t vecs [18];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled at the same point.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_line();
        hsync_i = 1'b1;
        den_i   = 1'b1;
        tick();
        hsync_i = 1'b0;
    endtask

    // ACK on consecutive cycles; each beat must produce a buffer write one cycle later.
    task automatic fetch_beats(input int n_beats, input logic [15:0] dbase, input logic [22:0] a0);
        for (int n = 0; n < n_beats; n++) begin
            ack_i = 1'b1;
            dat_i = dbase + 16'(n);
            tick();
            check($sformatf("beat%0d_we", n), 32'(lb_we_o), 32'd1);
            check($sformatf("beat%0d_idx", n), 32'(lb_adr_o), 32'(n));
            check($sformatf("beat%0d_dat", n), 32'(lb_dat_o), 32'(dbase + 16'(n)));
            if (n < WPL - 1)
                check($sformatf("beat%0d_adr", n), 32'(adr_o), 32'(a0 + 23'(n + 1)));
        end
        ack_i = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 23'h7F8000, 1'b0, 6'd0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 23'h7F8000, 1'b0, 6'd0, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 23'h7F8000, 1'b0, 6'd0, 16'h0000, 1'b0, 1'b1, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'hA000, 1'b1, 23'h7F8001, 1'b1, 6'd0, 16'hA000, 1'b0, 1'b1, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 23'h7F8001, 1'b0, 6'd0, 16'hA000, 1'b0, 1'b1, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'hA001, 1'b1, 23'h7F8002, 1'b1, 6'd1, 16'hA001, 1'b0, 1'b1, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 23'h7F8002, 1'b0, 6'd1, 16'hA001, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'hA002, 1'b1, 23'h7F8003, 1'b1, 6'd2, 16'hA002, 1'b0, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 23'h7F8003, 1'b0, 6'd2, 16'hA002, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'hA003, 1'b0, 23'h7F8004, 1'b1, 6'd3, 16'hA003, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'hBEEF, 1'b0, 23'h7F8004, 1'b0, 6'd3, 16'hA003, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 23'h7F8004, 1'b0, 6'd3, 16'hA003, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 23'h7F8004, 1'b0, 6'd3, 16'hA003, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'hB000, 1'b1, 23'h7F8005, 1'b1, 6'd0, 16'hB000, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 23'h7F8005, 1'b0, 6'd0, 16'hB000, 1'b1, 1'b1, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 16'hB001, 1'b1, 23'h7F8006, 1'b1, 6'd1, 16'hB001, 1'b1, 1'b1, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'hB002, 1'b1, 23'h7F8007, 1'b1, 6'd2, 16'hB002, 1'b1, 1'b1, 1'b0};
        vecs[17] = '{1'b0, 1'b1, 1'b0, 1'b1, 16'hB003, 1'b0, 23'h7F8008, 1'b1, 6'd3, 16'hB003, 1'b0, 1'b0, 1'b0};

        reset_ni = 1'b0;
        hsync_i  = 1'b0;
        vsync_i  = 1'b0;
        den_i    = 1'b0;
        fb_adr_i = 23'h7F8000;
        modulo_i = '0;
        dat_i    = '0;
        ack_i    = 1'b0;
`ifdef LINE_FETCHER_ERR_EN
        err_i    = 1'b0;
`endif
        tick();
        tick();
        check("rst_cyc", 32'(cyc_o), 32'd0);
        check("rst_stb", 32'(stb_o), 32'd0);
        check("rst_adr", 32'(adr_o), 32'd0);
        check("rst_we", 32'(lb_we_o), 32'd0);
        check("rst_sel", 32'(lb_sel_o), 32'd0);
        check("rst_lbadr", 32'(lb_adr_o), 32'd0);
        check("rst_lbdat", 32'(lb_dat_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_ovr", 32'(overrun_o), 32'd0);
`ifdef LINE_FETCHER_ERR_EN
        check("rst_err", 32'(err_o), 32'd0);
`endif
        reset_ni = 1'b1;

        // VSYNC load, stalled fetch, ACK outside a cycle, non-edge trigger, overrun mid-fetch.
        for (int i = 0; i < 18; i++) begin
            hsync_i = vecs[i].hs;
            den_i   = vecs[i].den;
            vsync_i = vecs[i].vs;
            ack_i   = vecs[i].ack;
            dat_i   = vecs[i].dat;
            tick();
            check($sformatf("r%0d_cyc", i), 32'(cyc_o), 32'(vecs[i].cyc));
            check($sformatf("r%0d_stb", i), 32'(stb_o), 32'(vecs[i].cyc));
            check($sformatf("r%0d_adr", i), 32'(adr_o), 32'(vecs[i].adr));
            check($sformatf("r%0d_we", i), 32'(lb_we_o), 32'(vecs[i].we));
            check($sformatf("r%0d_idx", i), 32'(lb_adr_o), 32'(vecs[i].lidx));
            check($sformatf("r%0d_dat", i), 32'(lb_dat_o), 32'(vecs[i].ldat));
            check($sformatf("r%0d_sel", i), 32'(lb_sel_o), 32'(vecs[i].sel));
            check($sformatf("r%0d_busy", i), 32'(busy_o), 32'(vecs[i].busy));
            check($sformatf("r%0d_ovr", i), 32'(overrun_o), 32'(vecs[i].ovr));
        end
        hsync_i = 1'b0;
        ack_i   = 1'b0;

        // Wrap: 0x7FFFF0 + 4 + 0x10 wraps to 0x000004.
        modulo_i = 23'h000010;
        fb_adr_i = 23'h7FFFF0;
        vsync_i  = 1'b1;
        tick();
        vsync_i  = 1'b0;
        check("wrap_vs_adr", 32'(adr_o), 32'h7FFFF0);
        start_line();
        check("wrap_start_cyc", 32'(cyc_o), 32'd1);
        check("wrap_start_adr", 32'(adr_o), 32'h7FFFF0);
        fetch_beats(WPL, 16'hC000, 23'h7FFFF0);
        check("wrap_end_cyc", 32'(cyc_o), 32'd0);
        check("wrap_end_adr", 32'(adr_o), 32'h000004);
        check("wrap_end_sel", 32'(lb_sel_o), 32'd1);

        // Negative modulo equal to the line length re-reads the same line.
        modulo_i = 23'h7FFFFC;
        start_line();
        check("neg_start_adr", 32'(adr_o), 32'h000004);
        fetch_beats(WPL, 16'hD000, 23'h000004);
        check("neg_end_adr", 32'(adr_o), 32'h000004);
        check("neg_end_sel", 32'(lb_sel_o), 32'd0);

        // VSYNC abort mid-fetch; the ACK in the VSYNC cycle and later ACKs must not write.
        fb_adr_i = 23'h123456;
        start_line();
        check("abort_start_cyc", 32'(cyc_o), 32'd1);
        fetch_beats(1, 16'hE000, 23'h000004);
        vsync_i = 1'b1;
        ack_i   = 1'b1;
        dat_i   = 16'hEEEE;
        tick();
        vsync_i = 1'b0;
        check("abort_cyc", 32'(cyc_o), 32'd0);
        check("abort_we", 32'(lb_we_o), 32'd0);
        check("abort_adr", 32'(adr_o), 32'h123456);
        check("abort_sel", 32'(lb_sel_o), 32'd0);
        check("abort_busy", 32'(busy_o), 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("abort_post%0d_we", k), 32'(lb_we_o), 32'd0);
            check($sformatf("abort_post%0d_cyc", k), 32'(cyc_o), 32'd0);
        end
        ack_i = 1'b0;

        // One full line to flip the buffer, then reset in the middle of the next fetch.
        start_line();
        fetch_beats(WPL, 16'hF000, 23'h123456);
        check("pre_rst_sel", 32'(lb_sel_o), 32'd1);
        check("pre_rst_adr", 32'(adr_o), 32'h123456);
        start_line();
        check("pre_rst_cyc", 32'(cyc_o), 32'd1);
        #2;
        reset_ni = 1'b0;
        #1;
        check("midrst_cyc", 32'(cyc_o), 32'd0);
        check("midrst_stb", 32'(stb_o), 32'd0);
        check("midrst_sel", 32'(lb_sel_o), 32'd0);
        check("midrst_adr", 32'(adr_o), 32'd0);
        check("midrst_busy", 32'(busy_o), 32'd0);
        @(posedge clk_i);
        #3;
        reset_ni = 1'b1;
        ack_i    = 1'b1;
        tick();
        tick();
        check("postrst_cyc", 32'(cyc_o), 32'd0);
        check("postrst_we", 32'(lb_we_o), 32'd0);
        ack_i = 1'b0;

`ifdef LINE_FETCHER_ERR_EN
        // ERR on beat 2: only indices 0..1 written, buffer flips, pointer advances, sticky until VSYNC.
        modulo_i = '0;
        fb_adr_i = 23'h000100;
        vsync_i  = 1'b1;
        tick();
        vsync_i  = 1'b0;
        start_line();
        fetch_beats(2, 16'h1110, 23'h000100);
        err_i = 1'b1;
        dat_i = 16'h9999;
        tick();
        err_i = 1'b0;
        check("err_cyc", 32'(cyc_o), 32'd0);
        check("err_we", 32'(lb_we_o), 32'd0);
        check("err_idx", 32'(lb_adr_o), 32'd1);
        check("err_sel", 32'(lb_sel_o), 32'd1);
        check("err_adr", 32'(adr_o), 32'h000104);
        check("err_flag", 32'(err_o), 32'd1);
        tick();
        check("err_sticky", 32'(err_o), 32'd1);
        vsync_i = 1'b1;
        tick();
        vsync_i = 1'b0;
        check("err_clear", 32'(err_o), 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
